// File: rtl/cpu_if_stage.sv
// Instruction fetch stage: owns the fetch PC, talks to instruction memory and
// loads the IF/ID pipeline register, honouring redirects, stalls and wait states.
module cpu_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h80000000,
  parameter logic [31:0] ILLOP_PC = 32'h80000004,
  parameter logic [31:0] XADR_PC  = 32'h80000008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  PCSrc,
  input  logic [31:0] ConBA,
  input  logic [25:0] JT,
  input  logic [31:0] DatabusA,
  input  logic        Stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_Instruct,
  output logic [31:0] IF_ID_PC,
  output logic        IF_ID_valid,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_inc, target, pc_nxt, instr_nxt, ifpc_nxt;
  logic        valid_nxt, redirect;

  // Memory handshake: imem_req is a level request for the word at imem_addr;
  // imem_ready=1 in a cycle means imem_data holds that word during that cycle
  // only. The request stays asserted until the word is accepted or abandoned.
  assign imem_req  = (state != BOOT);
  assign imem_addr = PC;
  assign dbg_state = state;

  // Supervisor bit (31) is sticky across sequential increments.
  assign pc_inc   = {PC[31], PC[30:0] + 31'd4};
  assign redirect = (state != BOOT) && (PCSrc >= 3'd1) && (PCSrc <= 3'd5);

  always_comb begin
    target = pc_inc;
    case (PCSrc)
      3'd1:    target = ConBA;
      3'd2:    target = {PC[31:28], JT, 2'b00};
      3'd3:    target = DatabusA;
      3'd4:    target = ILLOP_PC;
      3'd5:    target = XADR_PC;
      default: target = pc_inc;
    endcase
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = PC;
    instr_nxt = IF_ID_Instruct;
    ifpc_nxt  = IF_ID_PC;
    valid_nxt = IF_ID_valid;
    case (state)
      BOOT: state_nxt = FETCH;
      default: begin
        if (redirect) begin
          pc_nxt    = target;
          instr_nxt = 32'h0;
          ifpc_nxt  = 32'h0;
          valid_nxt = 1'b0;
          state_nxt = FETCH;
        end else if (Stall) begin
          // Hold everything; the same PC is refetched once the stall drops.
          state_nxt = state;
        end else if (imem_ready) begin
          pc_nxt    = pc_inc;
          instr_nxt = imem_data;
          ifpc_nxt  = pc_inc;
          valid_nxt = 1'b1;
          state_nxt = FETCH;
        end else begin
          instr_nxt = 32'h0;
          ifpc_nxt  = 32'h0;
          valid_nxt = 1'b0;
          state_nxt = WAIT;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= BOOT;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC             <= RESET_PC;
      IF_ID_Instruct <= 32'h0;
      IF_ID_PC       <= 32'h0;
      IF_ID_valid    <= 1'b0;
    end else begin
      PC             <= pc_nxt;
      IF_ID_Instruct <= instr_nxt;
      IF_ID_PC       <= ifpc_nxt;
      IF_ID_valid    <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_if_stage.sv
// Bench for cpu_if_stage: directed scenarios plus randomized traffic checked
// against a rule-level model of the fetch stage.
module tb_cpu_if_stage;

  localparam logic [31:0] RST_PC = 32'h80000000;
  localparam logic [31:0] ILL_PC = 32'h80000004;
  localparam logic [31:0] XAD_PC = 32'h80000008;

  logic        clk, reset;
  logic [2:0]  pcsrc;
  logic [31:0] conba, databusa, data;
  logic [25:0] jt;
  logic        stall, ready;
  logic        imem_req, if_id_valid;
  logic [31:0] imem_addr, pc, if_id_instr, if_id_pc;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  // reference model
  logic [31:0] m_pc, m_instr, m_ifpc;
  logic        m_valid, m_boot;
  bit          auto_data;

  cpu_if_stage dut (
    .clk(clk), .reset(reset), .PCSrc(pcsrc), .ConBA(conba), .JT(jt),
    .DatabusA(databusa), .Stall(stall), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(ready), .imem_data(data),
    .PC(pc), .IF_ID_Instruct(if_id_instr), .IF_ID_PC(if_id_pc),
    .IF_ID_valid(if_id_valid), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
  endfunction

  function automatic logic [31:0] plus4(input logic [31:0] a);
    return (a & 32'h80000000) | ((a + 32'd4) & 32'h7FFFFFFF);
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_instr = 0; m_ifpc = 0; m_valid = 0; m_boot = 1;
  endtask

  task automatic model_edge();
    int src;
    src = (pcsrc > 3'd5) ? 0 : int'(pcsrc);
    if (m_boot) m_boot = 0;
    else if (src != 0) begin
      case (src)
        1: m_pc = conba;
        2: m_pc = (m_pc & 32'hF0000000) + ({6'd0, jt} * 4);
        3: m_pc = databusa;
        4: m_pc = ILL_PC;
        default: m_pc = XAD_PC;
      endcase
      m_instr = 0; m_ifpc = 0; m_valid = 0;
    end else if (stall) begin
    end else if (ready) begin
      m_instr = data; m_pc = plus4(m_pc); m_ifpc = m_pc; m_valid = 1;
    end else begin
      m_instr = 0; m_ifpc = 0; m_valid = 0;
    end
  endtask

  // driver: one clock with the currently driven inputs
  task automatic step();
    if (auto_data) data = word_at(m_pc);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [31:0] v);
    pcsrc = 3'd3; databusa = v; stall = 0; ready = 0;
    step();
    pcsrc = 3'd0;
  endtask

  task automatic do_reset();
    reset = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
  endtask

  task automatic test_reset();
    pcsrc = 0; conba = 0; jt = 0; databusa = 0; stall = 0; ready = 0; data = 0;
    auto_data = 0;
    do_reset();
    total++; if (pc !== RST_PC) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, RST_PC); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    total++; if ({if_id_instr, if_id_pc, if_id_valid} !== 65'd0) begin
      bad++; $display("FAIL reset_ifid got=%h/%h/%b exp=0/0/0", if_id_instr, if_id_pc, if_id_valid);
    end
  endtask

  task automatic test_boot_seq();
    logic [31:0] exp_a[3];
    exp_a[0] = 32'h80000000; exp_a[1] = 32'h80000004; exp_a[2] = 32'h80000008;
    auto_data = 1; ready = 1; pcsrc = 0;
    step();  // BOOT cycle
    for (int i = 0; i < 3; i++) begin
      total++; if (imem_addr !== exp_a[i] || imem_req !== 1'b1) begin
        bad++; $display("FAIL boot_addr%0d got=%h req=%b exp=%h", i, imem_addr, imem_req, exp_a[i]);
      end
      step();
      total++; if (if_id_pc !== exp_a[i] + 4 || if_id_instr !== word_at(exp_a[i]) || if_id_valid !== 1'b1) begin
        bad++; $display("FAIL boot_ifid%0d got=%h/%h exp=%h/%h", i, if_id_pc, if_id_instr, exp_a[i] + 4, word_at(exp_a[i]));
      end
    end
  endtask

  task automatic test_jump();
    set_pc(32'h00000010);
    pcsrc = 3'd2; jt = 26'h0000040; ready = 1;
    step();
    pcsrc = 0;
    total++; if (pc !== 32'h00000100 || if_id_instr !== 0 || if_id_valid !== 0) begin
      bad++; $display("FAIL jump got=%h/%h/%b exp=00000100/0/0", pc, if_id_instr, if_id_valid);
    end
  endtask

  task automatic test_stall();
    set_pc(32'h0000001C);
    ready = 1; step();  // accept 1C, PC -> 20
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (pc !== 32'h20 || if_id_pc !== 32'h20 || if_id_instr !== word_at(32'h1C) || if_id_valid !== 1) begin
        bad++; $display("FAIL stall%0d got=%h/%h/%h exp=00000020/00000020/%h", i, pc, if_id_pc, if_id_instr, word_at(32'h1C));
      end
    end
    stall = 0; step();
    total++; if (pc !== 32'h24 || if_id_pc !== 32'h24 || if_id_instr !== word_at(32'h20)) begin
      bad++; $display("FAIL stall_release got=%h/%h/%h exp=00000024/00000024/%h", pc, if_id_pc, if_id_instr, word_at(32'h20));
    end
  endtask

  task automatic test_wait_redirect();
    set_pc(32'h00000040);
    ready = 0; step();
    total++; if (pc !== 32'h40 || if_id_valid !== 0 || imem_req !== 1) begin
      bad++; $display("FAIL wait1 got=%h/%b/%b exp=00000040/0/1", pc, if_id_valid, imem_req);
    end
    pcsrc = 3'd5; step(); pcsrc = 0;
    total++; if (pc !== XAD_PC || if_id_valid !== 0 || if_id_instr !== 0) begin
      bad++; $display("FAIL xadr got=%h/%b/%h exp=%h/0/0", pc, if_id_valid, if_id_instr, XAD_PC);
    end
    ready = 1; step();
    total++; if (if_id_pc !== 32'h8000000C || if_id_instr !== word_at(XAD_PC)) begin
      bad++; $display("FAIL after_xadr got=%h/%h exp=8000000c/%h", if_id_pc, if_id_instr, word_at(XAD_PC));
    end
  endtask

  task automatic test_illop_stall();
    set_pc(32'h00000080);
    pcsrc = 3'd4; stall = 1; ready = 1; step();
    pcsrc = 0; stall = 0;
    total++; if (pc !== ILL_PC || if_id_valid !== 0 || if_id_pc !== 0) begin
      bad++; $display("FAIL illop got=%h/%b/%h exp=%h/0/0", pc, if_id_valid, if_id_pc, ILL_PC);
    end
  endtask

  task automatic test_wrap();
    set_pc(32'h7FFFFFFC);
    ready = 1; step();
    total++; if (pc !== 0 || if_id_pc !== 0 || if_id_valid !== 1) begin
      bad++; $display("FAIL wrap_lo got=%h/%h/%b exp=0/0/1", pc, if_id_pc, if_id_valid);
    end
    set_pc(32'hFFFFFFFC);
    ready = 1; pcsrc = 3'd7; step(); pcsrc = 0;
    total++; if (pc !== 32'h80000000 || if_id_pc !== 32'h80000000) begin
      bad++; $display("FAIL wrap_hi got=%h/%h exp=80000000/80000000", pc, if_id_pc);
    end
  endtask

  task automatic test_reset_mid_wait();
    set_pc(32'h00000040);
    ready = 0; step();
    #2 reset = 0;
    model_reset();
    #1;
    total++; if (pc !== RST_PC || imem_req !== 0 || if_id_valid !== 0) begin
      bad++; $display("FAIL async_reset got=%h/%b/%b exp=%h/0/0", pc, imem_req, if_id_valid, RST_PC);
    end
    @(posedge clk); #1;
    reset = 1;
    auto_data = 0; ready = 1; data = 32'hDEADBEEF; pcsrc = 3'd1; conba = 32'h1234;
    step();  // BOOT: late data and PCSrc ignored
    total++; if (pc !== RST_PC || if_id_valid !== 0 || imem_addr !== RST_PC || imem_req !== 1) begin
      bad++; $display("FAIL boot_ignore got=%h/%b/%b exp=%h/0/1", pc, if_id_valid, imem_req, RST_PC);
    end
    pcsrc = 0; auto_data = 1; step();
    total++; if (if_id_pc !== RST_PC + 4 || if_id_instr !== word_at(RST_PC)) begin
      bad++; $display("FAIL first_fetch got=%h/%h exp=%h/%h", if_id_pc, if_id_instr, RST_PC + 4, word_at(RST_PC));
    end
  endtask

  task automatic test_random();
    auto_data = 0;
    for (int i = 0; i < 400; i++) begin
      pcsrc    = ($urandom_range(0, 9) < 6) ? 3'd0 : 3'($urandom_range(1, 7));
      conba    = $urandom;
      jt       = 26'($urandom);
      databusa = ($urandom_range(0, 7) == 0) ? 32'h7FFFFFFC : $urandom;
      stall    = ($urandom_range(0, 4) == 0);
      ready    = ($urandom_range(0, 9) < 7);
      data     = $urandom;
      step();
      total++; if (pc !== m_pc || imem_addr !== m_pc || imem_req !== !m_boot) begin
        bad++; $display("FAIL rand_pc%0d got=%h/%h/%b exp=%h/%b", i, pc, imem_addr, imem_req, m_pc, !m_boot);
      end
      total++; if (if_id_instr !== m_instr || if_id_pc !== m_ifpc || if_id_valid !== m_valid) begin
        bad++; $display("FAIL rand_ifid%0d got=%h/%h/%b exp=%h/%h/%b", i, if_id_instr, if_id_pc, if_id_valid, m_instr, m_ifpc, m_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_boot_seq();
    test_jump();
    test_stall();
    test_wait_redirect();
    test_illop_stall();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_if_stage.md
CPU_IF_STAGE -- requirements
Module: cpu_IF_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h80000000, boot fetch address.
REQ-002 SHALL have parameter ILLOP_PC, default 32'h80000004, interrupt entry address.
REQ-003 SHALL have parameter XADR_PC, default 32'h80000008, undefined-instruction entry address.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port PCSrc  input  3  next-PC select from decode: 000 PC+4, 001 branch, 010 J, 011 Jr, 100 ILLOP, 101 XADR.
REQ-007 SHALL have port ConBA  input  32  branch target.
REQ-008 SHALL have port JT  input  26  jump target field.
REQ-009 SHALL have port DatabusA  input  32  register jump target (jr/jalr).
REQ-010 SHALL have port Stall  input  1  hazard hold request.
REQ-011 SHALL have port imem_req  output  1  fetch request.
REQ-012 SHALL have port imem_addr  output  32  fetch address, always equal to PC.
REQ-013 SHALL have port imem_ready  input  1  imem_data valid this cycle.
REQ-014 SHALL have port imem_data  input  32  fetched instruction word.
REQ-015 SHALL have port PC  output  32  current fetch PC register.
REQ-016 SHALL have port IF_ID_Instruct  output  32  instruction to decode; 32'h0 is a bubble (decodes as nop).
REQ-017 SHALL have port IF_ID_PC  output  32  PC+4 of IF_ID_Instruct; bit 31 is the supervisor bit consumed by decode as PC31.
REQ-018 SHALL have port IF_ID_valid  output  1  IF_ID_Instruct holds a real fetched instruction.

Function
REQ-019 SHALL implement FSM states BOOT, FETCH, WAIT.
REQ-020 BOOT SHALL last exactly one cycle with imem_req=0, then go to FETCH.
REQ-021 FETCH and WAIT SHALL drive imem_req=1; FETCH with imem_ready=0 and no redirect SHALL go to WAIT; WAIT SHALL stay until imem_ready=1.
REQ-022 PC+4 SHALL be {PC[31], PC[30:0]+31'd4}: the supervisor bit never changes by increment, bits 30:0 wrap modulo 2^31.
REQ-023 Targets: 001 ConBA; 010 {PC[31:28], JT, 2'b00}; 011 DatabusA; 100 ILLOP_PC; 101 XADR_PC; 110/111 SHALL be treated as 000.
REQ-024 Accept (imem_ready=1, PCSrc=000, Stall=0, state FETCH/WAIT): IF_ID_Instruct<=imem_data, IF_ID_PC<=PC+4, IF_ID_valid<=1, PC<=PC+4, state FETCH.
REQ-025 Redirect (PCSrc 001..101, any state except BOOT): PC<=target, IF_ID loaded with bubble (Instruct 0, PC 0, valid 0), state FETCH, any imem_data that cycle discarded.
REQ-026 Redirect SHALL take priority over Stall and over imem_ready.
REQ-027 Stall=1 with PCSrc=000: PC, IF_ID_* held; imem_data that cycle discarded; the same PC is refetched after Stall drops.
REQ-028 No accept, no redirect, no stall (imem_ready=0): PC held, IF_ID loaded with bubble.
REQ-029 PCSrc during BOOT SHALL be ignored.
REQ-030 Latency: instruction available at imem_data in cycle N appears on IF_ID_Instruct in cycle N+1.

Reset
REQ-031 On reset low, asynchronously: PC=RESET_PC, state BOOT, IF_ID_Instruct=0, IF_ID_PC=0, IF_ID_valid=0, imem_req=0.
REQ-032 Reset asserted mid-WAIT SHALL abandon the outstanding fetch; data returned afterwards SHALL be ignored until the first FETCH after BOOT.
REQ-033 First fetch after reset release SHALL be at RESET_PC, issued in the cycle after BOOT.

Verification
REQ-034 Reset release, imem_ready=1, PCSrc=000 -> imem_addr 80000000, 80000004, 80000008 on consecutive cycles; IF_ID_PC 80000004 one cycle after first word.
REQ-035 PC=00000010, PCSrc=010, JT=26'h0000040 -> next PC 00000100, IF_ID_Instruct=0, IF_ID_valid=0 that cycle.
REQ-036 Stall=1 for 3 cycles at PC=00000020 with imem_ready=1 -> PC and IF_ID_* unchanged 3 cycles, then word from 00000020 accepted.
REQ-037 imem_ready=0 for 2 cycles at PC=00000040, PCSrc=101 in second cycle -> PC=80000008, late data for 00000040 discarded.
REQ-038 PCSrc=100 with Stall=1 at PC=00000080 -> PC=80000004 next cycle, bubble in IF_ID.
REQ-039 PC=7FFFFFFC, PCSrc=000, accept -> PC=00000000, IF_ID_PC=00000000; PC=FFFFFFFC -> PC=80000000.
